ifft_twiddle_sequencer: RTL and testbench
=========================================

# ifft_twiddle_sequencer

Address sequencer and stream controller for the IFFT twiddle ROMs (real and imaginary twiddle ROMs, 5-bit address, 16-bit registered data, one-cycle read latency). On a start request it walks every twiddle entry in stage/butterfly order. It drives one shared ROM address to both ROMs and qualifies the ROM outputs with a valid/ready handshake toward the butterfly datapath, so the datapath sees full throughput and can stall without losing or repeating entries.

## Interface
- NUM_STAGES, 7, number of twiddle groups (stages) walked per run
- BF_PER_STAGE, 4, entries per stage; must be a power of two
- ADDR_W, 5, ROM address width; NUM_STAGES*BF_PER_STAGE <= 2**ADDR_W
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  run request; sampled only in IDLE
- tw_ready  input  1  datapath accepts the current twiddle pair
- rom_addr  output  ADDR_W  address to both twiddle ROMs (combinational from state and tw_ready)
- tw_valid  output  1  ROM data_out of both ROMs is a valid twiddle this cycle
- tw_stage  output  $clog2(NUM_STAGES)  stage index of the twiddle currently on the ROM outputs
- tw_bf  output  $clog2(BF_PER_STAGE)  butterfly index within the stage
- tw_last_stage_entry  output  1  current entry is the last in its stage
- tw_last  output  1  current entry is the final entry of the run
- busy  output  1  high in PRIME, RUN and DONE
- done  output  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE: rom_addr=0; start=1 -> PRIME. start is ignored in all other states (no queuing).
- PRIME: rom_addr=0 presented for one cycle while the ROM fetches entry 0. Unconditional move to RUN.
- RUN: internal pointer ptr = index of the entry now on the ROM outputs (stage, bf counters). tw_valid=1.
  - fire = tw_valid & tw_ready.
  - rom_addr = fire ? addr(ptr+1) : addr(ptr), where addr(s,b) = s*BF_PER_STAGE + b. Lookahead is needed because the ROM is registered.
  - On fire: bf increments. At bf=BF_PER_STAGE-1, bf wraps to 0 and stage increments.
  - On fire with tw_last=1: go to DONE. rom_addr=0 in that cycle, not beyond the table.
  - tw_ready=0: ptr holds, rom_addr = addr(ptr), ROM outputs stay stable. tw_valid stays high (valid must not drop once raised until fire).
- DONE: tw_valid=0, done=1 for exactly one cycle. Then go to IDLE.
- Flags:
  - tw_last_stage_entry = (bf==BF_PER_STAGE-1) & tw_valid.
  - tw_last = tw_last_stage_entry & (stage==NUM_STAGES-1).
- Reset values (any state, including mid-run):
  - state=IDLE, ptr=0.
  - rom_addr=0, tw_valid=0, tw_stage=0, tw_bf=0.
  - tw_last_stage_entry=0, tw_last=0, busy=0, done=0.
  - A run interrupted by rst is abandoned; no done pulse.

## Timing
- start high at cycle 0 edge (IDLE) -> cycle 1 PRIME with rom_addr=0.
- Cycle 2: RUN, tw_valid=1, entry 0 on the ROM outputs.
- With tw_ready held high: entry k is valid at cycle 2+k, and rom_addr=k+1 in that cycle. Final entry 27 is valid at cycle 29 with tw_last=1.
- Cycle 30: done=1, busy=1, tw_valid=0. Cycle 31: IDLE, busy=0. Earliest restart is start at cycle 31.
- Each stall cycle (tw_ready=0 in RUN) adds exactly one cycle of latency. Total cycles from start to done = 2 + entries + stall cycles.
- No combinational path from start to any output. tw_ready reaches only rom_addr combinationally.

## Test plan
- Reset, then start with tw_ready=1 -> rom_addr sequence 0,0,1,2,…,27,0. tw_valid high in cycles 2–29. Real ROM data at entry 9 = 16'h00B5. done pulse at cycle 30.
- tw_ready=0 for cycles 5–7 (entry 3 current) -> rom_addr=3 and tw_bf=3 held. ROM data unchanged. Entry 4 appears at cycle 9. done at cycle 33.
- Stage boundaries -> tw_last_stage_entry high at entries 3,7,…,27. tw_stage increments the cycle after each of those fire. tw_last only at entry 27 (stage 6, bf 3).
- start pulsed during RUN and on the DONE cycle -> ignored. Exactly one done pulse. No second run begins until start is asserted in IDLE.
- rst asserted at cycle 15 mid-run -> next cycle all outputs at reset values, no done. A fresh start then restarts from entry 0.
- tw_ready toggling every cycle -> 28 fires total. Each entry accepted exactly once, in order, none skipped or duplicated.

Source files
------------

// File: rtl/ifft_twiddle_sequencer_if.sv
// Handshake bundle between the twiddle sequencer and the butterfly datapath.
// The master side drives ROM address, qualifiers and run status.
interface ifft_twiddle_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int STG_W  = 3,
  parameter int BF_W   = 2
);
  logic              start;
  logic              tw_ready;
  logic [ADDR_W-1:0] rom_addr;
  logic              tw_valid;
  logic [STG_W-1:0]  tw_stage;
  logic [BF_W-1:0]   tw_bf;
  logic              tw_last_stage_entry;
  logic              tw_last;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    input  tw_ready,
    output rom_addr,
    output tw_valid,
    output tw_stage,
    output tw_bf,
    output tw_last_stage_entry,
    output tw_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output tw_ready,
    input  rom_addr,
    input  tw_valid,
    input  tw_stage,
    input  tw_bf,
    input  tw_last_stage_entry,
    input  tw_last,
    input  busy,
    input  done
  );
endinterface

// File: rtl/ifft_twiddle_sequencer.sv
// Twiddle ROM address sequencer: walks stage/butterfly order and streams
// the registered ROM outputs to the datapath under valid/ready.
module ifft_twiddle_sequencer #(
  parameter int NUM_STAGES   = 7,
  parameter int BF_PER_STAGE = 4,
  parameter int ADDR_W       = 5
) (
  input  logic clk,
  input  logic rst,
  ifft_twiddle_sequencer_if.master tw_if
);

  localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int BF_W  = (BF_PER_STAGE > 1) ? $clog2(BF_PER_STAGE) : 1;
  localparam int BF_SH = $clog2(BF_PER_STAGE);

  localparam logic [STG_W-1:0] STG_MAX = STG_W'(NUM_STAGES - 1);
  localparam logic [BF_W-1:0]  BF_MAX  = BF_W'(BF_PER_STAGE - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [STG_W-1:0] r_stage;
  logic [BF_W-1:0]  r_bf;

  logic              w_run;
  logic              w_fire;
  logic              w_lse;
  logic              w_last;
  logic [STG_W-1:0]  w_stage_nxt;
  logic [BF_W-1:0]   w_bf_nxt;
  logic [ADDR_W-1:0] w_addr_cur;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_rom_addr;

  assign w_run  = (r_state == S_RUN);
  assign w_fire = w_run & tw_if.tw_ready;
  assign w_lse  = w_run & (r_bf == BF_MAX);
  assign w_last = w_lse & (r_stage == STG_MAX);

  assign w_bf_nxt    = w_lse ? '0 : r_bf + 1'b1;
  assign w_stage_nxt = w_lse ? r_stage + 1'b1 : r_stage;

  // BF_PER_STAGE is a power of two, so s*BF+b is a shift-or
  assign w_addr_cur = (ADDR_W'(r_stage) << BF_SH)
                    | ADDR_W'(r_bf);
  assign w_addr_nxt = (ADDR_W'(w_stage_nxt) << BF_SH)
                    | ADDR_W'(w_bf_nxt);

  // Lookahead on fire because the ROM data is registered
  always_comb begin
    w_rom_addr = '0;
    if (w_run) begin
      if (w_fire)
        w_rom_addr = w_last ? '0 : w_addr_nxt;
      else
        w_rom_addr = w_addr_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_stage <= '0;
          r_bf    <= '0;
          if (tw_if.start)
            r_state <= S_PRIME;
        end
        S_PRIME: r_state <= S_RUN;
        S_RUN: begin
          if (w_fire) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_stage <= '0;
              r_bf    <= '0;
            end else begin
              r_stage <= w_stage_nxt;
              r_bf    <= w_bf_nxt;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tw_if.rom_addr            = w_rom_addr;
  assign tw_if.tw_valid            = w_run;
  assign tw_if.tw_stage            = r_stage;
  assign tw_if.tw_bf               = r_bf;
  assign tw_if.tw_last_stage_entry = w_lse;
  assign tw_if.tw_last             = w_last;
  assign tw_if.busy                = (r_state != S_IDLE);
  assign tw_if.done                = (r_state == S_DONE);

endmodule

// File: tb/tb_ifft_twiddle_sequencer.sv
// Directed bench for ifft_twiddle_sequencer with a registered
// twiddle ROM model attached to rom_addr.
module tb_ifft_twiddle_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ifft_twiddle_sequencer_if #(.ADDR_W(5), .STG_W(3), .BF_W(2)) ifc ();

  ifft_twiddle_sequencer #(
    .NUM_STAGES  (7),
    .BF_PER_STAGE(4),
    .ADDR_W      (5)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tw_if(ifc.master)
  );

  int n_chk = 0;
  int n_err = 0;
  int done_seen = 0;

  function automatic logic [15:0] rom_re(input int a);
    if (a == 9) return 16'h00B5;
    return 16'h0100 + 16'(a);
  endfunction

  function automatic logic [15:0] rom_im(input int a);
    return 16'hF000 | 16'(a * 3);
  endfunction

  logic [15:0] rom_re_q = '0;
  logic [15:0] rom_im_q = '0;

  always @(posedge clk) begin
    rom_re_q <= rom_re(int'(ifc.rom_addr));
    rom_im_q <= rom_im(int'(ifc.rom_addr));
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.done === 1'b1) done_seen++;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, 32'(ifc.rom_addr), 0);
    chk({tag, "_valid"}, 32'(ifc.tw_valid), 0);
    chk({tag, "_stage"}, 32'(ifc.tw_stage), 0);
    chk({tag, "_bf"}, 32'(ifc.tw_bf), 0);
    chk({tag, "_lse"}, 32'(ifc.tw_last_stage_entry), 0);
    chk({tag, "_last"}, 32'(ifc.tw_last), 0);
    chk({tag, "_busy"}, 32'(ifc.busy), 0);
    chk({tag, "_done"}, 32'(ifc.done), 0);
  endtask

  // mode 0: ready held high, 1: stall cycles 5-7, 2: ready on odd cycles
  task automatic do_run(input int mode, input bit glitch);
    int c;
    int k;
    int stalls;
    int d0;
    bit rdy;
    d0 = done_seen;
    ifc.start = 1'b1;
    ifc.tw_ready = (mode == 0);
    #1;
    chk("idle_addr", 32'(ifc.rom_addr), 0);
    chk("idle_busy", 32'(ifc.busy), 0);
    tick();
    ifc.start = 1'b0;
    #1;
    chk("prime_busy", 32'(ifc.busy), 1);
    chk("prime_valid", 32'(ifc.tw_valid), 0);
    chk("prime_addr", 32'(ifc.rom_addr), 0);
    tick();
    c = 2;
    k = 0;
    stalls = 0;
    while (k < 28 && c < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(c >= 5 && c <= 7);
        default: rdy = (c % 2 == 1);
      endcase
      ifc.tw_ready = rdy;
      ifc.start = glitch && (c == 10);
      #1;
      chk("run_valid", 32'(ifc.tw_valid), 1);
      chk("run_busy", 32'(ifc.busy), 1);
      chk("run_done", 32'(ifc.done), 0);
      chk("run_stage", 32'(ifc.tw_stage), 32'(k / 4));
      chk("run_bf", 32'(ifc.tw_bf), 32'(k % 4));
      chk("run_lse", 32'(ifc.tw_last_stage_entry), 32'(k % 4 == 3));
      chk("run_last", 32'(ifc.tw_last), 32'(k == 27));
      chk("run_re", 32'(rom_re_q), 32'(rom_re(k)));
      chk("run_im", 32'(rom_im_q), 32'(rom_im(k)));
      if (rdy)
        chk("run_addr", 32'(ifc.rom_addr), (k == 27) ? 0 : 32'(k + 1));
      else
        chk("stall_addr", 32'(ifc.rom_addr), 32'(k));
      if (k == 9) chk("entry9_re", 32'(rom_re_q), 32'h00B5);
      if (mode == 1 && c == 9) chk("stall_entry4", 32'(k), 4);
      if (rdy) k++;
      else stalls++;
      tick();
      c++;
    end
    if (k < 28) chk("run_timeout", 32'(k), 28);
    ifc.tw_ready = 1'b0;
    ifc.start = glitch;
    #1;
    chk("done_pulse", 32'(ifc.done), 1);
    chk("done_cycle", 32'(c), 32'(30 + stalls));
    if (mode == 1) chk("done_cycle33", 32'(c), 33);
    chk("done_valid", 32'(ifc.tw_valid), 0);
    chk("done_busy", 32'(ifc.busy), 1);
    chk("done_addr", 32'(ifc.rom_addr), 0);
    tick();
    ifc.start = 1'b0;
    #1;
    chk("post_busy", 32'(ifc.busy), 0);
    chk("post_done", 32'(ifc.done), 0);
    repeat (5) begin
      tick();
      chk("idle_stays", 32'(ifc.busy), 0);
    end
    chk("one_done", 32'(done_seen - d0), 1);
  endtask

  initial begin
    int d0;
    ifc.start = 1'b0;
    ifc.tw_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();
    chk_reset_outs("idle");

    do_run(0, 1'b0);
    do_run(1, 1'b0);
    do_run(0, 1'b1);
    do_run(2, 1'b0);

    // Abort mid-run with reset at cycle 15
    d0 = done_seen;
    ifc.start = 1'b1;
    ifc.tw_ready = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (14) tick();
    chk("abort_running", 32'(ifc.tw_valid), 1);
    rst = 1'b1;
    tick();
    ifc.tw_ready = 1'b0;
    #1;
    chk_reset_outs("abort");
    rst = 1'b0;
    repeat (4) begin
      tick();
      chk("abort_idle", 32'(ifc.busy), 0);
    end
    chk("abort_no_done", 32'(done_seen - d0), 0);

    do_run(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
